// File: rtl/madd_chk_pkg.sv
// madd_chk_pkg
// Shared definitions for the exhaustive 2x2+2 multiply-add checker:
//   - chk_state_t : sweep controller states
//   - NVEC        : number of input vectors in a full sweep (2^VEC_W)
//   - *_W         : field widths for vectors, results and accumulators
//   - exact_madd  : golden a*b+c reference used by the error stage
package madd_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } chk_state_t;

    localparam int NVEC  = 64;
    localparam int VEC_W = 6;
    localparam int RES_W = 4;
    localparam int CNT_W = 7;
    localparam int SUM_W = 10;

    // Largest value is 3*3+3 = 12, so four bits always hold the result.
    function automatic logic [RES_W-1:0] exact_madd(input logic [1:0] a,
                                                    input logic [1:0] b,
                                                    input logic [1:0] c);
        logic [RES_W-1:0] prod;
        prod = {2'b00, a} * {2'b00, b};
        return prod + {2'b00, c};
    endfunction

endpackage

// File: rtl/madd_err_acc.sv
// madd_err_acc
// Error stage of the checker: compares the registered approximate response
// against the exact multiply-add and accumulates statistics.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   clear         : zero all accumulators (start of a new sweep)
//   valid         : s1_vec/s1_approx hold a sample to accumulate
//   s1_vec        : registered stimulus vector {c, b, a}
//   s1_approx     : registered approximate response
//   max_err       : largest absolute error so far
//   err_count     : number of samples whose error exceeds ET
//   sum_err       : sum of absolute errors
module madd_err_acc
    import madd_chk_pkg::*;
#(
    parameter int ET = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             valid,
    input  logic [5:0]       s1_vec,
    input  logic [3:0]       s1_approx,
    output logic [3:0]       max_err,
    output logic [6:0]       err_count,
    output logic [9:0]       sum_err
);

    // A 4-bit error can never exceed 15, so larger thresholds behave as 15.
    localparam int               ET_C = (ET > 15) ? 15 : ET;
    localparam logic [RES_W-1:0] ET_L = RES_W'(ET_C);

    logic [1:0]       field [3];
    logic [RES_W-1:0] exact;
    logic [RES_W-1:0] err;
    logic             over;

    logic [RES_W-1:0] max_err_reg;
    logic [CNT_W-1:0] err_count_reg;
    logic [SUM_W-1:0] sum_err_reg;

    // Operand fields: a = vec[1:0], b = vec[3:2], c = vec[5:4].
    for (genvar gi = 0; gi < 3; gi++) begin : g_field
        assign field[gi] = s1_vec[2*gi+1 -: 2];
    end

    always_comb begin
        exact = exact_madd(field[0], field[1], field[2]);
        err   = (s1_approx >= exact) ? (s1_approx - exact) : (exact - s1_approx);
        over  = (err > ET_L);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            max_err_reg   <= '0;
            err_count_reg <= '0;
            sum_err_reg   <= '0;
        end else if (valid) begin
            if (err > max_err_reg) begin
                max_err_reg <= err;
            end
            err_count_reg <= err_count_reg + CNT_W'(over);
            sum_err_reg   <= sum_err_reg + SUM_W'(err);
        end
    end

    assign max_err   = max_err_reg;
    assign err_count = err_count_reg;
    assign sum_err   = sum_err_reg;

endmodule

// File: rtl/madd_exhaustive_checker.sv
// madd_exhaustive_checker
// Sweeps all 64 input vectors of an external approximate 2x2+2 multiply-add,
// registers each response, and reports error statistics against the exact
// result once the sweep has drained.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (wins over start)
//   start      : begin a sweep (accepted in IDLE or DONE only)
//   vec_out    : stimulus to the approximate madd, bit i drives in<i>
//   approx_in  : combinational response of the approximate madd
//   busy       : sweep or drain in progress
//   done       : results valid
//   pass       : done and no threshold violations
//   max_err, err_count, sum_err : sweep statistics
module madd_exhaustive_checker
    import madd_chk_pkg::*;
#(
    parameter int ET   = 8,
    parameter int NVEC = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [5:0] vec_out,
    input  logic [3:0] approx_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] max_err,
    output logic [6:0] err_count,
    output logic [9:0] sum_err
);

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NVEC - 1);

    chk_state_t       state_reg, state_next;
    logic [VEC_W-1:0] vec_reg;
    logic [VEC_W-1:0] s1_vec_reg;
    logic [RES_W-1:0] s1_approx_reg;
    logic             s1_valid_reg;

    logic start_ok;
    logic last_vec;

    // start is only honoured when no sweep is in flight.
    assign start_ok = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign last_vec = (vec_reg == LAST_VEC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (start)    state_next = SWEEP;
            SWEEP: if (last_vec) state_next = DRAIN;
            // The last stage-1 entry is consumed by the accumulators on the
            // same edge that leaves DRAIN, so both stages are empty in DONE.
            DRAIN: state_next = DONE;
            DONE:  if (start)    state_next = SWEEP;
            default: state_next = IDLE;
        endcase
    end

    // Vector counter doubles as vec_out; it parks on the last vector
    // outside SWEEP so the stimulus stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_reg <= '0;
        end else if (start_ok) begin
            vec_reg <= '0;
        end else if ((state_reg == SWEEP) && !last_vec) begin
            vec_reg <= vec_reg + 1'b1;
        end
    end

    // Stage 1: capture the vector with its combinational response.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_vec_reg    <= '0;
            s1_approx_reg <= '0;
        end else begin
            s1_valid_reg <= (state_reg == SWEEP);
            if (state_reg == SWEEP) begin
                s1_vec_reg    <= vec_reg;
                s1_approx_reg <= approx_in;
            end
        end
    end

    // Stage 2: error computation and accumulation.
    madd_err_acc #(
        .ET (ET)
    ) u_err_acc (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok),
        .valid     (s1_valid_reg),
        .s1_vec    (s1_vec_reg),
        .s1_approx (s1_approx_reg),
        .max_err   (max_err),
        .err_count (err_count),
        .sum_err   (sum_err)
    );

    assign vec_out = vec_reg;
    assign busy    = (state_reg == SWEEP) || (state_reg == DRAIN);
    assign done    = (state_reg == DONE);
    assign pass    = done && (err_count == '0);

endmodule

// File: doc/madd_exhaustive_checker.md
MADD_EXHAUSTIVE_CHECKER -- requirements
Module: madd_exhaustive_checker

Interface
REQ-001 SHALL have parameter ET, default 8, meaning the error threshold; a sample whose absolute error exceeds ET counts as a violation.
REQ-002 SHALL have parameter NVEC, default 64, meaning the number of input vectors swept; it is fixed at 2^6.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to begin a sweep.
REQ-006 SHALL have port vec_out, output, 6 bits: stimulus to the approximate madd, with bit i driving in<i>.
REQ-007 SHALL have port approx_in, input, 4 bits: combinational response of the approximate madd, with bit i taken from out<i>.
REQ-008 SHALL have port busy, output, 1 bit: high while in SWEEP or DRAIN.
REQ-009 SHALL have port done, output, 1 bit: high in the DONE state, when the results are valid.
REQ-010 SHALL have port pass, output, 1 bit: high when done and err_count==0.
REQ-011 SHALL have port max_err, output, 4 bits: largest absolute error seen in the sweep.
REQ-012 SHALL have port err_count, output, 7 bits: number of violations.
REQ-013 SHALL have port sum_err, output, 10 bits: sum of absolute errors; 64*15=960 fits, so no saturation is needed.

Function
REQ-014 SHALL compute the exact result as a*b+c (4 bits unsigned, maximum 12), where a={vec[1],vec[0]}, b={vec[3],vec[2]} and c={vec[5],vec[4]}.
REQ-015 SHALL implement the FSM states IDLE, SWEEP, DRAIN and DONE.
REQ-016 SHALL make these transitions: IDLE->SWEEP on start; SWEEP->DRAIN after vector 63 is presented; DRAIN->DONE once the pipeline is empty; DONE->SWEEP on start.
REQ-017 SHALL, on entry to SWEEP, clear max_err, err_count and sum_err, and set the vector counter to 0.
REQ-018 SHALL, in SWEEP, drive vec_out from the counter and increment it by 1 each cycle, presenting vectors 0..63 on 64 consecutive cycles.
REQ-019 SHALL hold vec_out at the last value presented (63) outside SWEEP; after reset vec_out=0.
REQ-020 SHALL, at stage 1, register {vec_out, approx_in} with a valid bit at the end of each SWEEP cycle.
REQ-021 SHALL, at stage 2, compute the exact result and err=|approx-exact| (4 bits) from the stage-1 registers and update the accumulators at the next edge.
REQ-022 SHALL, at stage 2, update max_err as max(max_err, err), increment err_count when err>ET, and add err to sum_err.
REQ-023 SHALL stay in DRAIN until the stage-1 and stage-2 valid bits have cleared; done rises exactly 2 cycles after the cycle in which vector 63 is presented.
REQ-024 SHALL ignore start while in SWEEP or DRAIN, with no restart and no effect on the accumulators.
REQ-025 SHALL, on start in DONE, restart the sweep with cleared results; done falls on the next cycle.
REQ-026 SHALL keep the result outputs stable in IDLE and DONE.
REQ-027 SHALL make pass combinational from state and err_count, so pass=0 whenever done=0.
REQ-028 SHALL give start and rst the same-cycle priority rst > start.

Reset
REQ-029 SHALL, on rst, go to IDLE and clear the counter, both valid bits, vec_out, max_err, err_count and sum_err; busy, done and pass all read 0.
REQ-030 SHALL, on rst mid-sweep, abandon the sweep, leave no partial results visible, and require a new start.

Structure
REQ-031 SHALL place the state enum, NVEC, the field widths (VEC_W=6, RES_W=4, CNT_W=7, SUM_W=10) and an exact_madd(a,b,c) function in the shared package madd_chk_pkg.
REQ-032 SHALL implement the error stage as the sub-module madd_err_acc: it takes the stage-1 registers, clear and valid, and outputs max_err, err_count and sum_err.
REQ-033 SHALL instantiate the approximate madd outside this block; the checker only connects to it through vec_out and approx_in.

Verification
REQ-034 SHALL verify the ideal DUT (approx_in=exact): start -> done after 66 cycles, pass=1, max_err=0, err_count=0, sum_err=0.
REQ-035 SHALL verify constant approx_in=0 with ET=8: max_err=12, err_count=6, sum_err=240, pass=0.
REQ-036 SHALL verify the approximate madd from the library with ET=8: every per-vector err<=8, err_count=0 and pass=1.
REQ-037 SHALL verify that start pulsed at vector 20 during SWEEP is ignored: vectors stay contiguous 0..63 and the results match the case without the pulse.
REQ-038 SHALL verify rst asserted at vector 30: next cycle IDLE, all outputs 0; a subsequent start gives results identical to a clean run.
REQ-039 SHALL verify back-to-back runs, with start in DONE and a different approx model: the second run's results exclude the first run's accumulators.
